sha_mem_host: RTL and testbench
===============================

SHA_MEM_HOST -- requirements
Module: sha_mem_host

Interface
REQ-001 SHALL have parameter NUM_OF_WORDS, default 40: message length in 32-bit words.
REQ-002 SHALL have parameter MEM_WORDS, default 64: internal word-memory depth.
REQ-003 SHALL have parameter MSG_BASE, default 16'h0000: word address of message region.
REQ-004 SHALL have parameter HASH_BASE, default 16'h0030: word address of 8-word hash region.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum RUN duration.
REQ-006 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: load_valid  in  1; load_ready  out  1; load_data  in  32  host message word stream.
REQ-008 SHALL have ports: result_valid  out  1; result_ready  in  1; result_data  out  32  hash word stream, H0 first.
REQ-009 SHALL have ports: busy  out  1  high outside LOAD; err  out  1  sticky timeout flag.
REQ-010 SHALL have ports: eng_start  out  1; eng_done  in  1; input_addr  out  16  =MSG_BASE; hash_addr  out  16  =HASH_BASE.
REQ-011 SHALL have ports: eng_addr  in  16; eng_we  in  1; eng_wdata  in  32; eng_rdata  out  32  engine memory port, clocked by clk.

Function
REQ-012 SHALL implement FSM states LOAD, KICK, RUN, DRAIN; reset state LOAD.
REQ-013 LOAD: load_ready=1; each load_valid&load_ready writes load_data to mem[MSG_BASE+cnt], cnt++.
REQ-014 LOAD: on the accept of word NUM_OF_WORDS-1, the next state SHALL be KICK, cnt cleared, err cleared.
REQ-015 KICK: eng_start=1 held until eng_done samples 0, then RUN; eng_start=0 in all other states.
REQ-016 RUN: wd counter increments each cycle; eng_done=1 -> DRAIN; wd reaching TIMEOUT_CYCLES-1 -> err=1, LOAD.
REQ-017 Engine read: eng_rdata registered, equal to mem[eng_addr] one cycle after eng_addr presented (1-cycle latency), every state.
REQ-018 Engine read of eng_addr>=MEM_WORDS SHALL return 32'h0 one cycle later.
REQ-019 Engine write: eng_we=1 in RUN writes eng_wdata to mem[eng_addr] at clk edge; ignored outside RUN or when eng_addr>=MEM_WORDS.
REQ-020 Read-during-write same address SHALL return old data.
REQ-021 DRAIN: result_valid=1, result_data=mem[HASH_BASE+idx]; on valid&ready idx++; after idx=7 transfer -> LOAD.
REQ-022 result_data SHALL be stable while result_valid=1 and result_ready=0.
REQ-023 Host port SHALL not access memory in KICK/RUN; load_ready=0 and result_valid=0 there.
REQ-024 busy SHALL be 1 in KICK, RUN, DRAIN; 0 in LOAD.
REQ-025 cnt width clog2(NUM_OF_WORDS+1); idx 3 bits; wd clog2(TIMEOUT_CYCLES) bits, cleared on entry to RUN.

Reset
REQ-026 rst_n=0 SHALL force state LOAD, cnt=0, idx=0, wd=0, err=0, eng_start=0, result_valid=0, eng_rdata=0, load_ready=1 asynchronously.
REQ-027 Memory array SHALL not be reset; a reset mid-operation discards the transaction and the host must reload all words.

Structure
REQ-028 Package sha_mem_pkg SHALL hold the state enum and default constants (NUM_OF_WORDS, MSG_BASE, HASH_BASE, HASH_WORDS=8).
REQ-029 Sub-module sha_word_ram SHALL implement the MEM_WORDS x 32 synchronous RAM: one write port (muxed host/engine), one registered read port for the engine, one for DRAIN.

Verification
REQ-030 Load words 32'h00000000..32'h00000027 with real engine attached -> after DRAIN, 8 result words match software SHA-256 of the 160-byte message.
REQ-031 In RUN, eng_addr=5 at cycle N -> eng_rdata=mem[5] at cycle N+1; eng_addr=16'h0100 -> eng_rdata=0.
REQ-032 Hold eng_done=1 in KICK for 3 cycles -> eng_start stays 1; drop eng_done -> RUN next cycle, eng_start=0.
REQ-033 eng_done stuck 0 in RUN -> err=1 and state LOAD after 4096 cycles; err clears after next full load.
REQ-034 DRAIN with result_ready low 3 cycles on word 2 -> result_data constant, no word skipped, exactly 8 transfers.
REQ-035 Assert rst_n=0 after 10 words loaded -> load_ready=1, busy=0, next 40 accepted words start at MSG_BASE.

Source files
------------

// File: rtl/sha_mem_pkg.sv
// -----------------------------------------------------------------------------
// sha_mem_pkg
// Shared definitions for the SHA host/memory wrapper: the controller state
// encoding and the default memory map / sizing constants used as parameter
// defaults by sha_mem_host.
// -----------------------------------------------------------------------------
package sha_mem_pkg;

  // Default message length in 32-bit words (160-byte message).
  localparam int          NUM_OF_WORDS   = 40;
  // Default word-memory depth.
  localparam int          MEM_WORDS      = 64;
  // Default word address of the message region.
  localparam logic [15:0] MSG_BASE       = 16'h0000;
  // Default word address of the hash region (H0..H7).
  localparam logic [15:0] HASH_BASE      = 16'h0030;
  // Number of words in a SHA-256 digest.
  localparam int          HASH_WORDS     = 8;
  // Default upper bound on the engine run time, in clock cycles.
  localparam int          TIMEOUT_CYCLES = 4096;

  // LOAD : host streams message words into memory
  // KICK : engine start request held until eng_done is seen low
  // RUN  : engine owns the memory port, watchdog counting
  // DRAIN: hash words streamed back to the host
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_KICK  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/sha_word_ram.sv
// -----------------------------------------------------------------------------
// sha_word_ram
// MEM_WORDS x 32 synchronous word RAM with one write port and two registered
// read ports. Out-of-range addresses are ignored on write and read back as
// zero. A read of the address being written in the same cycle returns the
// previous contents.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset (read registers only)
//   we, waddr, wdata  write port (already muxed between host and engine)
//   eng_raddr         engine read address
//   eng_rdata         engine read data, valid one cycle after eng_raddr
//   drn_raddr         drain read address
//   drn_rdata         drain read data, valid one cycle after drn_raddr
// -----------------------------------------------------------------------------
module sha_word_ram #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [15:0] waddr,
  input  logic [31:0] wdata,
  input  logic [15:0] eng_raddr,
  output logic [31:0] eng_rdata,
  input  logic [15:0] drn_raddr,
  output logic [31:0] drn_rdata
);

  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [15:0] addr);
    return {16'h0000, addr} < 32'(MEM_WORDS);
  endfunction

  // NOTE: the array has no reset branch on purpose -- a reset would turn the
  // RAM into MEM_WORDS*32 flops; stale contents are harmless because every
  // transaction starts by reloading the whole message.
  always_ff @(posedge clk) begin
    if (we && in_range(waddr)) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  // NOTE: non-blocking assignments here are what make a same-cycle read of
  // the written address see the old word: the read samples mem before the
  // write above takes effect at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_rdata <= '0;
      drn_rdata <= '0;
    end else begin
      eng_rdata <= in_range(eng_raddr) ? mem[eng_raddr[IW-1:0]] : 32'h0;
      drn_rdata <= in_range(drn_raddr) ? mem[drn_raddr[IW-1:0]] : 32'h0;
    end
  end

endmodule

// File: rtl/sha_mem_host.sv
// -----------------------------------------------------------------------------
// sha_mem_host
// Host-side wrapper around a memory-mapped SHA-256 engine. The host streams
// NUM_OF_WORDS message words in, the engine is kicked and runs against the
// shared word memory, and the 8 hash words are streamed back out (H0 first).
// A watchdog aborts a run that exceeds TIMEOUT_CYCLES and raises sticky err.
//
// Ports
//   clk, rst_n                              clock, async active-low reset
//   load_valid/load_ready/load_data         host message word stream (in)
//   result_valid/result_ready/result_data   hash word stream (out)
//   busy                                    high whenever not in LOAD
//   err                                     sticky timeout flag, cleared by a
//                                           completed load
//   eng_start/eng_done                      engine handshake
//   input_addr/hash_addr                    memory map constants for engine
//   eng_addr/eng_we/eng_wdata/eng_rdata     engine memory port (1-cycle read)
// -----------------------------------------------------------------------------
module sha_mem_host #(
  parameter int          NUM_OF_WORDS   = sha_mem_pkg::NUM_OF_WORDS,
  parameter int          MEM_WORDS      = sha_mem_pkg::MEM_WORDS,
  parameter logic [15:0] MSG_BASE       = sha_mem_pkg::MSG_BASE,
  parameter logic [15:0] HASH_BASE      = sha_mem_pkg::HASH_BASE,
  parameter int          TIMEOUT_CYCLES = sha_mem_pkg::TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_data,
  output logic        busy,
  output logic        err,
  output logic        eng_start,
  input  logic        eng_done,
  output logic [15:0] input_addr,
  output logic [15:0] hash_addr,
  input  logic [15:0] eng_addr,
  input  logic        eng_we,
  input  logic [31:0] eng_wdata,
  output logic [31:0] eng_rdata
);

  import sha_mem_pkg::*;

  localparam int CW = $clog2(NUM_OF_WORDS + 1);
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [WW-1:0] wd, wd_d;
  logic          err_d;
  // The drain read port is registered, so the first DRAIN cycle only fetches
  // H0; result_valid is withheld until the fetched word is on result_data.
  // This also guarantees the engine's final hash writes have landed.
  logic          drain_primed, drain_primed_d;

  logic          ram_we;
  logic [15:0]   ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   drn_rdata;

  assign input_addr  = MSG_BASE;
  assign hash_addr   = HASH_BASE;
  assign result_data = drn_rdata;

  sha_word_ram #(
    .MEM_WORDS (MEM_WORDS)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (ram_we),
    .waddr     (ram_waddr),
    .wdata     (ram_wdata),
    .eng_raddr (eng_addr),
    .eng_rdata (eng_rdata),
    .drn_raddr (HASH_BASE + 16'(idx_d)),
    .drn_rdata (drn_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_LOAD;
      cnt          <= '0;
      idx          <= '0;
      wd           <= '0;
      err          <= 1'b0;
      drain_primed <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      idx          <= idx_d;
      wd           <= wd_d;
      err          <= err_d;
      drain_primed <= drain_primed_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    idx_d          = idx;
    wd_d           = wd;
    err_d          = err;
    drain_primed_d = 1'b0;
    load_ready     = 1'b0;
    result_valid   = 1'b0;
    eng_start      = 1'b0;
    busy           = 1'b1;
    ram_we         = 1'b0;
    ram_waddr      = eng_addr;
    ram_wdata      = eng_wdata;

    unique case (state)
      ST_LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b0;
        idx_d      = '0;
        ram_we     = load_valid;
        ram_waddr  = MSG_BASE + 16'(cnt);
        ram_wdata  = load_data;
        if (load_valid) begin
          if (cnt == CW'(NUM_OF_WORDS - 1)) begin
            state_d = ST_KICK;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end

      ST_KICK: begin
        // A done left high from the previous job must be seen low before
        // the engine is considered started.
        eng_start = 1'b1;
        if (!eng_done) begin
          state_d = ST_RUN;
          wd_d    = '0;
        end
      end

      ST_RUN: begin
        ram_we = eng_we;
        if (eng_done) begin
          state_d = ST_DRAIN;
        end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_LOAD;
          err_d   = 1'b1;
        end else begin
          wd_d = wd + WW'(1);
        end
      end

      ST_DRAIN: begin
        drain_primed_d = 1'b1;
        result_valid   = drain_primed;
        if (drain_primed && result_ready) begin
          idx_d = idx + 3'd1;
          if (idx == 3'(HASH_WORDS - 1)) begin
            state_d        = ST_LOAD;
            drain_primed_d = 1'b0;
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

endmodule

// File: tb/tb_sha_mem_host.sv
// -----------------------------------------------------------------------------
// tb_sha_mem_host
// Directed bench for sha_mem_host. A behavioural SHA-256 engine drives the
// engine port; expected digests are computed from the loaded message and
// queued, then popped as DRAIN delivers words.
// -----------------------------------------------------------------------------
module tb_sha_mem_host;

  localparam int          NW = 40;
  localparam int          MW = 64;
  localparam logic [15:0] MB = 16'h0000;
  localparam logic [15:0] HB = 16'h0030;
  localparam int          TO = 4096;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] result_data;
  logic        busy;
  logic        err;
  logic        eng_start;
  logic        eng_done = 1'b0;
  logic [15:0] input_addr;
  logic [15:0] hash_addr;
  logic [15:0] eng_addr = '0;
  logic        eng_we = 1'b0;
  logic [31:0] eng_wdata = '0;
  logic [31:0] eng_rdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] msg [NW];
  logic [255:0] first_digest;

  sha_mem_host #(
    .NUM_OF_WORDS   (NW),
    .MEM_WORDS      (MW),
    .MSG_BASE       (MB),
    .HASH_BASE      (HB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .busy         (busy),
    .err          (err),
    .eng_start    (eng_start),
    .eng_done     (eng_done),
    .input_addr   (input_addr),
    .hash_addr    (hash_addr),
    .eng_addr     (eng_addr),
    .eng_we       (eng_we),
    .eng_wdata    (eng_wdata),
    .eng_rdata    (eng_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- software SHA-256 ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    logic [255:0] v, res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = st;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    v = {a, b, c, d, e, f, g, h};
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = st[255 - 32*i -: 32] + v[255 - 32*i -: 32];
    return res;
  endfunction

  function automatic logic [255:0] sha_words(input logic [31:0] m [NW]);
    localparam int NB = (NW * 32 + 64) / 512 + 1;
    logic [31:0]  p [NB*16];
    logic [511:0] blk;
    logic [255:0] st;
    for (int i = 0; i < NB*16; i++) p[i] = 32'h0;
    for (int i = 0; i < NW; i++) p[i] = m[i];
    p[NW]        = 32'h8000_0000;
    p[NB*16 - 1] = 32'(NW * 32);
    st = H_INIT;
    for (int bi = 0; bi < NB; bi++) begin
      for (int j = 0; j < 16; j++) blk[511 - 32*j -: 32] = p[16*bi + j];
      st = sha_compress(st, blk);
    end
    return st;
  endfunction

  // ---------------- host-side stimulus ----------------
  task automatic load_word(input logic [31:0] w);
    int guard = 0;
    load_valid = 1'b1;
    load_data  = w;
    while (!load_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!load_ready) check("load_ready_wait", 32'(load_ready), 32'd1);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic push_expected();
    logic [255:0] dg;
    dg = sha_words(msg);
    for (int i = 0; i < 8; i++) exp_q.push_back(dg[255 - 32*i -: 32]);
  endtask

  task automatic wait_start();
    int guard = 0;
    while (!eng_start && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("eng_start_seen", 32'(eng_start), 32'd1);
  endtask

  // Behavioural engine: entered at a negedge in KICK with eng_done low.
  task automatic run_engine(input bit extra);
    logic [31:0]  cap [NW];
    logic [255:0] dg;
    @(negedge clk);
    check("run_entry_start", 32'(eng_start), 32'd0);
    check("run_entry_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NW; i++) begin
      eng_addr = MB + 16'(i);
      @(negedge clk);
      cap[i] = eng_rdata;
    end
    if (extra) begin
      check("eng_rd_addr5", cap[5], msg[5]);
      eng_addr = 16'h0100;
      @(negedge clk);
      check("eng_rd_oob_zero", eng_rdata, 32'h0);
      eng_addr  = MB + 16'd3;
      eng_we    = 1'b1;
      eng_wdata = 32'hdead_beef;
      @(negedge clk);
      eng_we = 1'b0;
      check("eng_rdw_old", eng_rdata, msg[3]);
      @(negedge clk);
      check("eng_rdw_new", eng_rdata, 32'hdead_beef);
      eng_we    = 1'b1;
      eng_wdata = msg[3];
      @(negedge clk);
      eng_addr  = 16'(MW);
      eng_wdata = 32'hbad0_bad0;
      @(negedge clk);
      eng_we   = 1'b0;
      eng_addr = MB;
      @(negedge clk);
      check("eng_oob_wr_ignored", eng_rdata, msg[0]);
      check("run_still_busy", 32'(busy), 32'd1);
    end
    dg = sha_words(cap);
    for (int i = 0; i < 8; i++) begin
      eng_addr  = HB + 16'(i);
      eng_wdata = dg[255 - 32*i -: 32];
      eng_we    = 1'b1;
      @(negedge clk);
    end
    eng_we   = 1'b0;
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
  endtask

  task automatic drain(input int stall_word, input int stall_n);
    int          xfers = 0;
    int          guard = 0;
    int          stalled = 0;
    logic [31:0] held = '0;
    logic [31:0] exp_w;
    while (xfers < 8 && guard < 200) begin
      if (result_valid) begin
        if (xfers == stall_word && stalled < stall_n) begin
          result_ready = 1'b0;
          if (stalled == 0) held = result_data;
          else check("drain_stall_stable", result_data, held);
          stalled++;
        end else begin
          result_ready = 1'b1;
          exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : ~result_data;
          check($sformatf("drain_word%0d", xfers), result_data, exp_w);
          xfers++;
        end
      end else begin
        result_ready = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    result_ready = 1'b0;
    check("drain_xfer_count", 32'(xfers), 32'd8);
    check("drain_end_busy", 32'(busy), 32'd0);
    check("drain_end_valid", 32'(result_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [255:0] dg;
    int           n;

    // Software model self-check against the published "abc" digest.
    dg = sha_compress(H_INIT, {32'h6162_6380, 448'h0, 32'h0000_0018});
    for (int i = 0; i < 8; i++)
      check($sformatf("sha_abc_w%0d", i), dg[255 - 32*i -: 32], ABC_DIGEST[255 - 32*i -: 32]);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_eng_rdata", eng_rdata, 32'h0);
    check("input_addr", 32'(input_addr), 32'(MB));
    check("hash_addr", 32'(hash_addr), 32'(HB));
    rst_n = 1'b1;
    @(negedge clk);

    // Transaction 1: words 0..0x27, engine port probes, DRAIN stall on word 2.
    for (int i = 0; i < NW; i++) msg[i] = 32'(i);
    first_digest = sha_words(msg);
    for (int i = 0; i < NW; i++) load_word(msg[i]);
    push_expected();
    wait_start();
    check("kick_busy", 32'(busy), 32'd1);
    check("kick_load_ready", 32'(load_ready), 32'd0);
    check("kick_result_valid", 32'(result_valid), 32'd0);
    run_engine(1'b1);
    drain(2, 3);

    // Engine writes outside RUN are ignored; engine reads work in LOAD.
    eng_addr  = HB;
    eng_we    = 1'b1;
    eng_wdata = 32'h1234_5678;
    @(negedge clk);
    eng_we = 1'b0;
    @(negedge clk);
    check("eng_wr_ignored_load", eng_rdata, first_digest[255 -: 32]);

    // Transaction 2: engine never finishes -> watchdog.
    for (int i = 0; i < NW; i++) msg[i] = $urandom;
    for (int i = 0; i < NW; i++) load_word(msg[i]);
    wait_start();
    @(negedge clk);
    check("to_run_entry", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    check("to_run_cycles", 32'(n), 32'(TO));
    check("to_err_set", 32'(err), 32'd1);
    check("to_load_ready", 32'(load_ready), 32'd1);

    // Transaction 3: err sticky until full load; eng_done high during KICK.
    for (int i = 0; i < NW; i++) msg[i] = $urandom;
    load_word(msg[0]);
    check("err_sticky", 32'(err), 32'd1);
    eng_done = 1'b1;
    for (int i = 1; i < NW; i++) load_word(msg[i]);
    push_expected();
    check("err_cleared", 32'(err), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("kick_hold_start%0d", k), 32'(eng_start), 32'd1);
      @(negedge clk);
    end
    eng_done = 1'b0;
    run_engine(1'b0);
    drain(-1, 0);

    // Transaction 4: reset after 10 words, then a full fresh load.
    eng_addr = HB;
    for (int i = 0; i < 10; i++) load_word($urandom);
    rst_n = 1'b0;
    #1;
    check("mid_rst_load_ready", 32'(load_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_eng_rdata", eng_rdata, 32'h0);
    check("mid_rst_eng_start", 32'(eng_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NW; i++) msg[i] = $urandom;
    for (int i = 0; i < NW; i++) load_word(msg[i]);
    push_expected();
    wait_start();
    run_engine(1'b0);
    drain(-1, 0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
